// File: rtl/ones_pattern_gen_if.sv
// Request/response bundle for ones_pattern_gen: start/count in, result/done/sat out.
// With ONES_PATTERN_CHECK_EN defined the bundle also carries the self-check error flag.
interface ones_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             start;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             sat;
`ifdef ONES_PATTERN_CHECK_EN
    logic             error;

    modport master (output start, count, input result, done, sat, error);
    modport slave  (input start, count, output result, done, sat, error);
`else
    modport master (output start, count, input result, done, sat);
    modport slave  (input start, count, output result, done, sat);
`endif
endinterface

// File: rtl/ones_pattern_gen.sv
// Serial thermometer-code generator: builds a WIDTH-bit word with `count` MSB-justified 1s,
// one bit per clock. ONES_PATTERN_CHECK_EN adds a popcount self-check driving `error`.
module ones_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    ones_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    a, i, a_init;
    logic [WIDTH-1:0] result;
    logic             done, sat, sat_init, last, bit_in;

    // Widen by one bit so counts up to 2^CW-1 compare correctly against WIDTH.
    assign sat_init = {1'b0, bus.count} > (CW + 1)'(WIDTH);
    assign a_init   = sat_init ? CW'(WIDTH) : bus.count;
    assign last     = (i == CW'(WIDTH - 1));
    assign bit_in   = (a != '0);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_SHIFT;
            S_SHIFT: if (last)      state_nxt = S_DONE;
            S_DONE:  if (!bus.start) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a      <= '0;
            i      <= '0;
            result <= '0;
            sat    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: if (bus.start) begin
                    a      <= a_init;
                    sat    <= sat_init;
                    i      <= '0;
                    result <= '0;
                end
                S_SHIFT: begin
                    result <= {result[WIDTH-2:0], bit_in};
                    if (bit_in) a <= a - 1'b1;
                    i <= i + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result;
    assign bus.done   = done;
    assign bus.sat    = sat;

`ifdef ONES_PATTERN_CHECK_EN
    logic [CW-1:0] pop, tgt;
    logic          error;

    always_ff @(posedge clk) begin
        if (reset) begin
            pop   <= '0;
            tgt   <= '0;
            error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    pop   <= '0;
                    tgt   <= a_init;
                    error <= 1'b0;
                end
                S_SHIFT: begin
                    pop <= pop + CW'(bit_in);
                    // Include the bit shifted on this final edge in the compare.
                    if (last) error <= ((pop + CW'(bit_in)) != tgt);
                end
                default: ;
            endcase
        end
    end

    assign bus.error = error;
`endif
endmodule

// File: tb/tb_ones_pattern_gen.sv
// Randomized self-checking bench for ones_pattern_gen against a thermometer-code reference.
module tb_ones_pattern_gen;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    ones_pattern_gen_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    ones_pattern_gen #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: top min(n,WIDTH) bits set, the rest clear.
    function automatic logic [WIDTH-1:0] model(input int n);
        logic [WIDTH-1:0] r = '0;
        int m = (n > WIDTH) ? WIDTH : n;
        for (int b = 0; b < m; b++) r[WIDTH-1-b] = 1'b1;
        return r;
    endfunction

    task automatic check_err();
`ifdef ONES_PATTERN_CHECK_EN
        chk("error", 32'(bus.error), 32'd0);
`endif
    endtask

    // One request: hold keeps start high through done; chg alters count after accept.
    task automatic run(input int n, input bit hold, input bit chg);
        int lat = 0;
        bus.count = CW'(n);
        bus.start = 1'b1;
        step();
        if (chg) bus.count = CW'($urandom_range(0, (1 << CW) - 1));
        if (!hold) bus.start = 1'b0;
        while (!bus.done && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(WIDTH));
        chk("result", 32'(bus.result), 32'(model(n)));
        chk("sat", 32'(bus.sat), 32'(n > WIDTH));
        chk("popcnt", 32'($countones(bus.result)), 32'((n > WIDTH) ? WIDTH : n));
        check_err();
        if (hold) begin
            step();
            step();
            chk("done_hold", 32'(bus.done), 32'd1);
            chk("hold_result", 32'(bus.result), 32'(model(n)));
            bus.start = 1'b0;
        end
        step();
        chk("done_drop", 32'(bus.done), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.count = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sat", 32'(bus.sat), 32'd0);
        check_err();

        run(3, 1'b1, 1'b0);
        run(0, 1'b0, 1'b0);
        run(8, 1'b0, 1'b0);
        run(12, 1'b1, 1'b0);
        run(5, 1'b0, 1'b1);

        // Reset during the fourth shift cycle aborts the run.
        bus.count = CW'(5);
        bus.start = 1'b1;
        step();
        bus.count = CW'(1);
        bus.start = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_sat", 32'(bus.sat), 32'd0);
        run(5, 1'b0, 1'b0);

        // Back-to-back: run() ends one cycle after start drops in S_DONE.
        run(7, 1'b1, 1'b0);
        run(2, 1'b1, 1'b0);

        for (int n = 0; n <= WIDTH; n++) run(n, 1'b0, 1'b0);

        for (int k = 0; k < 30; k++)
            run(int'($urandom_range(0, (1 << CW) - 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
